// File: rtl/fifo_sync_ft.sv
// fifo_sync_ft: single-clock FIFO with arbitrary depth, occupancy count,
// almost-full/almost-empty thresholds and selectable first-word-fall-through.
//
// Ports:
//   iClk            clock, rising edge
//   iRst            synchronous active-high reset
//   iEnW / iEnR     push / pop requests (ignored when full / empty)
//   iClr            synchronous flush (pointers, count, flags, oData)
//   iData / oData   write / read data, BITWIDTH bits
//   oFull, oEmpty, oAFull, oAEmpty   flags derived from the registered count
//   oCount          current occupancy, $clog2(DEPTH+1) bits
//   oOvf / oUdf     sticky overflow / underflow, present only when
//                   FIFO_SYNC_FT_ERR_EN is defined
//
// FWFT=0: oData is loaded from the head on an accepted pop.
// FWFT=1: oData shows the head word whenever not empty, else 0.
module fifo_sync_ft #(
   parameter int unsigned BITWIDTH  = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AFULL_TH  = 6,
   parameter int unsigned AEMPTY_TH = 2,
   parameter int unsigned FWFT      = 0
) (
   input  logic                         iClk,
   input  logic                         iRst,
   input  logic                         iEnW,
   input  logic                         iEnR,
   input  logic                         iClr,
   input  logic [BITWIDTH-1:0]          iData,
   output logic [BITWIDTH-1:0]          oData,
   output logic                         oFull,
   output logic                         oEmpty,
   output logic                         oAFull,
   output logic                         oAEmpty,
   output logic [$clog2(DEPTH+1)-1:0]   oCount
`ifdef FIFO_SYNC_FT_ERR_EN
   ,
   output logic                         oOvf,
   output logic                         oUdf
`endif
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [BITWIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          afull_q, afull_d;
   logic          aempty_q, aempty_d;
   logic          push_ok, pop_ok;

   // Wrap at DEPTH-1 so non power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   // Request acceptance, pointer/count update and flag derivation.
   always_comb begin
      push_ok  = iEnW && !full_q;
      pop_ok   = iEnR && !empty_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (iClr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= CW'(AFULL_TH));
      aempty_d = (count_d <= CW'(AEMPTY_TH));
   end

   // Control state registers.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= (AFULL_TH == 0);
         aempty_q <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
      end
   end

   // Storage; contents survive reset and flush.
   always_ff @(posedge iClk) begin
      if (!iRst && !iClr && push_ok) mem_q[wr_ptr_q] <= iData;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word shown directly, masked to 0 while empty.
         assign oData = empty_q ? '0 : mem_q[rd_ptr_q];
      end else begin : g_reg_read
         logic [BITWIDTH-1:0] data_q, data_d;

         always_comb begin
            data_d = data_q;
            if (iClr)        data_d = '0;
            else if (pop_ok) data_d = mem_q[rd_ptr_q];
         end

         always_ff @(posedge iClk) begin
            if (iRst) data_q <= '0;
            else      data_q <= data_d;
         end

         assign oData = data_q;
      end
   endgenerate

   assign oCount  = count_q;
   assign oFull   = full_q;
   assign oEmpty  = empty_q;
   assign oAFull  = afull_q;
   assign oAEmpty = aempty_q;

`ifdef FIFO_SYNC_FT_ERR_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // Sticky error flags, cleared only by reset or flush.
   always_comb begin
      ovf_d = ovf_q | (iEnW & full_q);
      udf_d = udf_q | (iEnR & empty_q);
      if (iClr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign oOvf = ovf_q;
   assign oUdf = udf_q;
`endif

endmodule

// File: doc/fifo_sync_ft.md
Name: fifo_sync_ft

Overview:
- Parametrised single-clock FIFO; next generation of the team's basic fifo_sync.
- Adds arbitrary (non power-of-two) depth, occupancy count, programmable almost-full/almost-empty thresholds, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between stochastic/unary compute stages as an elastic buffer. Also used as a stream-rate decoupler in front of accumulators.

Parameters:
- BITWIDTH, 8, data word width (>=1)
- DEPTH, 8, number of entries (>=2; need not be a power of two)
- AFULL_TH, 6, oAFull asserts when count >= AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, oAEmpty asserts when count <= AEMPTY_TH (0..DEPTH-1)
- FWFT, 0, 0 = registered read (data one cycle after pop); 1 = head word visible on oData whenever not empty

Ports:
- iClk  in  1  clock, all logic on rising edge
- iRst  in  1  synchronous, active-high reset
- iEnW  in  1  push request
- iEnR  in  1  pop request
- iClr  in  1  synchronous flush
- iData  in  BITWIDTH  write data
- oData  out  BITWIDTH  read data
- oFull  out  1  count == DEPTH
- oEmpty  out  1  count == 0
- oAFull  out  1  count >= AFULL_TH
- oAEmpty  out  1  count <= AEMPTY_TH
- oCount  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (iRst=1 at a rising edge):
  - Write/read pointers and count go to 0. oData=0.
  - oEmpty=1, oFull=0, oAEmpty=1, oAFull=(AFULL_TH==0 ? 1 : 0), which is 0 for all legal values.
- Priority: iRst > iClr > push/pop.
  - iClr has the same effect as reset on pointers, count and flags.
  - Memory contents are not cleared. oData goes to 0.
- Push is accepted iff iEnW && !oFull. iData is written at wr_ptr, and wr_ptr advances.
- Pop is accepted iff iEnR && !oEmpty. rd_ptr advances.
- Rejected requests are ignored: no state change, no error signalled (see optional feature).
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - On full, a push is rejected even if a pop is accepted in the same cycle; no pass-through.
  - On empty, a pop is rejected even with a simultaneous push; no bypass.
- Pointer wrap: pointer increments from DEPTH-1 to 0 (explicit compare, not modulo 2^n).
- oCount, oFull, oEmpty, oAFull, oAEmpty are registered/derived from the registered count. All update on the edge after the accepting cycle.
- FWFT=0:
  - oData is registered. On an accepted pop, oData <= mem[rd_ptr] at that edge, so data is valid in the cycle after the pop.
  - oData holds its value otherwise, including across rejected pops.
- FWFT=1:
  - oData = mem[rd_ptr] when !oEmpty, else 0 (masked).
  - First written word appears on oData the cycle after the push that made the FIFO non-empty.
  - An accepted pop shows the next word, or 0 if emptied, after the edge.
- Memory is read-after-write safe: a write and a read to the same address in one cycle cannot occur, because full/empty gating forbids it.

Optional Feature:
- Macro FIFO_SYNC_FT_ERR_EN.
- Defined:
  - Adds outputs oOvf and oUdf (1 bit each, reset 0).
  - oOvf sets sticky on iEnW && oFull. oUdf sets sticky on iEnR && oEmpty.
  - Both clear only on iRst or iClr.
- Not defined: ports are absent and rejected requests are silently dropped.

Test Plan:
- Reset/flags:
  - Stimulus: DEPTH=8, AFULL_TH=6, AEMPTY_TH=2, FWFT=0; hold iRst 2 cycles, release.
  - Required: oCount=0, oEmpty=1, oAEmpty=1, oFull=0, oAFull=0, oData=0.
- Fill/drain:
  - Stimulus: push 0x01..0x08 on consecutive cycles.
  - Required during fill: oAEmpty drops when oCount=3; oAFull rises at oCount=6; oFull=1 at oCount=8. A 9th push (0xFF) is rejected, oCount stays 8.
  - Required on drain: pop 8 times, oData returns 0x01..0x08, each one cycle after its pop.
- Wrap and simultaneous:
  - Stimulus: DEPTH=5; push 3, then 10 cycles of simultaneous push/pop with an incrementing pattern.
  - Required: oCount stays 3, data order preserved across pointer wrap 4->0.
- FWFT:
  - Stimulus: FWFT=1; push 0xA5 then 0x3C.
  - Required: oData=0xA5 the cycle after the first push with no pop. After one pop, oData=0x3C. After a second pop, oData=0 and oEmpty=1.
- Clear priority:
  - Stimulus: with 4 entries held, assert iClr together with iEnW=1 and iEnR=1.
  - Required: next cycle oCount=0, oEmpty=1, the push is not stored.
  - Stimulus: with iRst and iClr both high. Required: reset behaviour.
- Error flags (FIFO_SYNC_FT_ERR_EN):
  - Stimulus: pop when empty. Required: oUdf=1, stays 1 after later pushes.
  - Stimulus: fill to DEPTH, push again. Required: oOvf=1.
  - Stimulus: iClr. Required: both flags return to 0.
